// File: rtl/vedic_div16x8.sv
// Sequential 16/8 unsigned restoring divider with start/busy/done handshake, one quotient bit
// per clock. Define VEDIC_DIV_ZERO_FAST_EN to finish divide-by-zero one cycle after start.
module vedic_div16x8 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [15:0] i_dividend,
    input  logic [7:0]  i_divisor,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_quotient,
    output logic [7:0]  o_remainder,
    output logic        o_div_zero
);

    typedef enum logic [1:0] {StIdle, StRun, StZero, StDone} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_r;
    logic [15:0] r_q;
    logic [7:0]  r_d;
    logic [4:0]  r_cnt;
    logic [15:0] r_quot;
    logic [7:0]  r_rem;
    logic        r_dz;

    logic [8:0]  w_t;
    logic [7:0]  w_nd;
    logic [7:0]  w_diff;
    logic        w_ge;
    logic [7:0]  w_r_next;
    logic [15:0] w_q_next;
    logic        w_last;
    logic        w_zero_last;

    assign w_t  = {r_r, r_q[15]};
    assign w_nd = ~r_d;

    // Ripple chain of T + ~{0,D} + 1; carry-out set means T >= D. The top sum bit is never
    // kept because a kept result is always below D.
    always_comb begin : trial_sub
        logic w_c;
        w_c    = 1'b1;
        w_diff = '0;
        for (int i = 0; i < 8; i++) begin
            w_diff[i] = w_t[i] ^ w_nd[i] ^ w_c;
            w_c       = (w_t[i] & w_nd[i]) | (w_c & (w_t[i] ^ w_nd[i]));
        end
        w_ge = w_t[8] | w_c;
    end

    assign w_r_next = w_ge ? w_diff : w_t[7:0];
    assign w_q_next = {r_q[14:0], w_ge};
    assign w_last   = (r_cnt == 5'd15);

`ifdef VEDIC_DIV_ZERO_FAST_EN
    assign w_zero_last = 1'b1;
`else
    assign w_zero_last = w_last;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle, StDone: begin
                if (i_start) begin
                    w_state_next = (i_divisor != 8'd0) ? StRun : StZero;
                end else begin
                    w_state_next = StIdle;
                end
            end
            StRun:   w_state_next = w_last ? StDone : StRun;
            StZero:  w_state_next = w_zero_last ? StDone : StZero;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_busy = (r_state == StRun) || (r_state == StZero);
        o_done = (r_state == StDone);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_r    <= '0;
            r_q    <= '0;
            r_d    <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dz   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    if (i_start) begin
                        r_q   <= i_dividend;
                        r_d   <= i_divisor;
                        r_r   <= '0;
                        r_cnt <= '0;
                    end
                end
                StRun: begin
                    r_r   <= w_r_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (w_last) begin
                        r_quot <= w_q_next;
                        r_rem  <= w_r_next;
                        r_dz   <= 1'b0;
                    end
                end
                StZero: begin
                    // Q still holds the untouched dividend here.
                    r_cnt <= r_cnt + 5'd1;
                    if (w_zero_last) begin
                        r_quot <= 16'hFFFF;
                        r_rem  <= r_q[7:0];
                        r_dz   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_quotient  = r_quot;
    assign o_remainder = r_rem;
    assign o_div_zero  = r_dz;

endmodule

// File: tb/tb_vedic_div16x8.sv
// Self-checking bench for vedic_div16x8: directed cases, handshake corner cases and random
// operands checked against plain integer division.
module tb_vedic_div16x8;

`ifdef VEDIC_DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 16;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;

    int n_chk  = 0;
    int n_fail = 0;

    vedic_div16x8 dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_dividend  (dividend),
        .i_divisor   (divisor),
        .o_busy      (busy),
        .o_done      (done),
        .o_quotient  (quotient),
        .o_remainder (remainder),
        .o_div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done !== 1'b1 && lat < 40);
    endtask

    task automatic check_result(input string tag, input logic [15:0] a, input logic [7:0] b);
        logic [15:0] eq;
        logic [7:0]  er;
        eq = (b == 8'd0) ? 16'hFFFF : a / {8'd0, b};
        er = (b == 8'd0) ? a[7:0] : 8'(a % {8'd0, b});
        check({tag, ":q"}, {16'd0, quotient}, {16'd0, eq});
        check({tag, ":r"}, {24'd0, remainder}, {24'd0, er});
        check({tag, ":dz"}, {31'd0, div_zero}, {31'd0, (b == 8'd0)});
    endtask

    task automatic run_div(input string tag, input logic [15:0] a, input logic [7:0] b);
        int lat;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start = 1'b0;
        check({tag, ":busy"}, {31'd0, busy}, 32'd1);
        wait_done(lat);
        check({tag, ":lat"}, lat, (b == 8'd0) ? ZLAT : 16);
        check_result(tag, a, b);
        @(negedge clk);
        check({tag, ":pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int          lat;
        int          ndone;
        logic [7:0]  ra;
        logic [7:0]  rb;
        logic [15:0] rd;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst:q", {16'd0, quotient}, 32'd0);
        check("rst:r", {24'd0, remainder}, 32'd0);
        check("rst:flags", {29'd0, busy, done, div_zero}, 32'd0);

        run_div("d1000_7", 16'h03E8, 8'h07);
        check("d1000_7:q_const", {16'd0, quotient}, 32'h008E);
        check("d1000_7:r_const", {24'd0, remainder}, 32'h06);
        run_div("ffff_ff", 16'hFFFF, 8'hFF);
        run_div("00fe_ff", 16'h00FE, 8'hFF);
        run_div("zero", 16'h1234, 8'h00);
        check("zero:r_const", {24'd0, remainder}, 32'h34);
        run_div("after_zero", 16'h0001, 8'h01);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom_range(1, 255));
            run_div("prod", 16'(ra * rb), rb);
            check("prod:q_is_a", {16'd0, quotient}, {24'd0, ra});
        end

        for (int i = 0; i < 300; i++) begin
            rd = 16'($urandom);
            rb = 8'($urandom_range(0, 255));
            run_div("rand", rd, rb);
            if (rb != 8'd0) begin
                check("rand:inv", {16'd0, quotient} * {24'd0, rb} + {24'd0, remainder},
                      {16'd0, rd});
                check("rand:rem_lt", {31'd0, (remainder < rb)}, 32'd1);
            end
        end

        // Starts while busy must be ignored.
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'hBEEF;
        divisor  = 8'h13;
        @(negedge clk);
        start    = 1'b0;
        dividend = 16'h1234;
        divisor  = 8'h05;
        ndone    = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                check("ovl:lat", cyc, 16);
                check_result("ovl", 16'hBEEF, 8'h13);
            end
            start = (cyc == 3 || cyc == 8);
        end
        start = 1'b0;
        check("ovl:ndone", ndone, 1);

        // Reset mid-division aborts with no done.
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'hABCD;
        divisor  = 8'h21;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort:q", {16'd0, quotient}, 32'd0);
        check("abort:r", {24'd0, remainder}, 32'd0);
        check("abort:flags", {29'd0, busy, done, div_zero}, 32'd0);
        ndone = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("abort:ndone", ndone, 0);
        run_div("post_rst", 16'hABCD, 8'h21);

        // Reset beats a simultaneous start.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start:busy", {31'd0, busy}, 32'd0);
        check("rst_start:q", {16'd0, quotient}, 32'd0);

        // Start held through the done cycle is accepted immediately.
        @(negedge clk);
        start    = 1'b1;
        dividend = 16'h7777;
        divisor  = 8'h0B;
        @(negedge clk);
        wait_done(lat);
        check("held1:lat", lat, 16);
        check_result("held1", 16'h7777, 8'h0B);
        dividend = 16'h4321;
        divisor  = 8'h2A;
        @(negedge clk);
        start = 1'b0;
        check("held2:busy", {31'd0, busy}, 32'd1);
        wait_done(lat);
        check("held2:lat", lat, 16);
        check_result("held2", 16'h4321, 8'h2A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
